// File: rtl/oflow_feature_extraction_pipe_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : oflow_feature_extraction_pipe_if
// Description : Bbox input stream and feature output stream of the feature
//               extraction pipe, grouped into one bundle.
//               slave  : the feature extraction pipe (consumes bbox, produces
//                        features)
//               master : the environment (bbox buffer + registration)
// Revision    : 1.0 - initial release
// ============================================================================
interface oflow_feature_extraction_pipe_if #(
    parameter int COORD_W = 11,
    parameter int DIM_W   = 8,
    parameter int COLOR_W = 24,
    parameter int CNT_W   = 8
);
    localparam int BBOX_W = 2*COORD_W + 2*DIM_W + 2*COLOR_W;

    // bbox stream {x_tl,y_tl,width,height,color1,color2}
    logic [BBOX_W-1:0]    bbox;
    logic                 bbox_valid;
    logic                 bbox_ready;

    // feature stream (FIFO head)
    logic [2*COORD_W-1:0] cm_concate;
    logic [4*COORD_W-1:0] position_concate;
    logic [DIM_W-1:0]     width;
    logic [DIM_W-1:0]     height;
    logic [COLOR_W-1:0]   color1;
    logic [COLOR_W-1:0]   color2;
    logic [CNT_W-1:0]     obj_idx;
    logic                 clip;
    logic                 feat_valid;
    logic                 feat_ready;

    modport master (
        output bbox, bbox_valid, feat_ready,
        input  bbox_ready, cm_concate, position_concate, width, height,
               color1, color2, obj_idx, clip, feat_valid
    );

    modport slave (
        input  bbox, bbox_valid, feat_ready,
        output bbox_ready, cm_concate, position_concate, width, height,
               color1, color2, obj_idx, clip, feat_valid
    );
endinterface
`default_nettype wire

// File: rtl/oflow_feature_extraction_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : oflow_feature_extraction_pipe
// Description : Batch feature extractor. Accepts num_obj bbox vectors, computes
//               bottom-right corner and centre of mass per object through one
//               register stage, and queues the results in an output FIFO for
//               registration. Pulses done_fe once every object has been popped.
// Build macro : OFLOW_FE_CLAMP_EN - saturate x_br/y_br/x_cm/y_cm at
//               X_MAX/Y_MAX and flag clip; otherwise sums wrap and clip is 0.
// Ports       : clk, reset_N (async active-low)
//               start_fe/num_obj/abort_fe - batch control from core_fsm
//               bus (slave)              - bbox in, feature FIFO head out
//               busy, done_fe            - batch status to core_fsm
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_feature_extraction_pipe #(
    parameter int COORD_W    = 11,
    parameter int DIM_W      = 8,
    parameter int COLOR_W    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int X_MAX      = 2047,
    parameter int Y_MAX      = 2047
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 start_fe,
    input  logic [CNT_W-1:0]     num_obj,
    input  logic                 abort_fe,
    oflow_feature_extraction_pipe_if.slave bus,
    output logic                 busy,
    output logic                 done_fe
);
    localparam int BBOX_W = 2*COORD_W + 2*DIM_W + 2*COLOR_W;
    localparam int ENT_W  = 6*COORD_W + 2*DIM_W + 2*COLOR_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [COORD_W:0] c_X_LIM = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] c_Y_LIM = (COORD_W+1)'(Y_MAX);
`ifdef OFLOW_FE_CLAMP_EN
    localparam bit c_CLAMP_EN = 1'b1;
`else
    localparam bit c_CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_q, acc_q, pop_q;
    logic                s1_valid_q;
    logic [ENT_W-1:0]    s1_data_q;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      cnt_q;

    // Returns {clip, value}; saturation only when the clamp build is enabled.
    function automatic logic [COORD_W:0] sat(input logic [COORD_W:0] sum,
                                             input logic [COORD_W:0] lim);
        if (c_CLAMP_EN && (sum > lim))
            sat = {1'b1, lim[COORD_W-1:0]};
        else
            sat = {1'b0, sum[COORD_W-1:0]};
    endfunction

    // ---------------- bbox unpack and arithmetic ----------------
    logic [COORD_W-1:0] w_x_tl, w_y_tl;
    logic [DIM_W-1:0]   w_wid, w_hgt;
    logic [COLOR_W-1:0] w_c1, w_c2;
    logic [COORD_W:0]   w_xbr, w_ybr, w_xcm, w_ycm;
    logic               w_clip;
    logic [ENT_W-1:0]   w_entry;

    assign w_x_tl = bus.bbox[BBOX_W-1 -: COORD_W];
    assign w_y_tl = bus.bbox[BBOX_W-COORD_W-1 -: COORD_W];
    assign w_wid  = bus.bbox[2*COLOR_W+2*DIM_W-1 -: DIM_W];
    assign w_hgt  = bus.bbox[2*COLOR_W+DIM_W-1 -: DIM_W];
    assign w_c1   = bus.bbox[2*COLOR_W-1 -: COLOR_W];
    assign w_c2   = bus.bbox[COLOR_W-1:0];

    // One extra bit of headroom so overflow is visible to the clamp.
    assign w_xbr = sat({1'b0, w_x_tl} + (COORD_W+1)'(w_wid), c_X_LIM);
    assign w_ybr = sat({1'b0, w_y_tl} + (COORD_W+1)'(w_hgt), c_Y_LIM);
    assign w_xcm = sat({1'b0, w_x_tl} + (COORD_W+1)'(w_wid >> 1), c_X_LIM);
    assign w_ycm = sat({1'b0, w_y_tl} + (COORD_W+1)'(w_hgt >> 1), c_Y_LIM);
    assign w_clip = w_xbr[COORD_W] | w_ybr[COORD_W] | w_xcm[COORD_W] | w_ycm[COORD_W];

    assign w_entry = {w_xcm[COORD_W-1:0], w_ycm[COORD_W-1:0],
                      w_x_tl, w_y_tl, w_xbr[COORD_W-1:0], w_ybr[COORD_W-1:0],
                      w_wid, w_hgt, w_c1, w_c2, w_clip};

    // ---------------- handshakes ----------------
    logic [PTR_W+1:0] w_occ;
    logic             w_accept, w_pop, w_push;
    logic [ENT_W-1:0] w_head;

    // Stage-1 counts as occupied so a FIFO slot is always reserved for it.
    assign w_occ          = (PTR_W+2)'(cnt_q) + (PTR_W+2)'(s1_valid_q);
    assign bus.bbox_ready = (state_q == S_RUN) && (acc_q < num_q) &&
                            (w_occ < (PTR_W+2)'(FIFO_DEPTH));
    assign w_accept       = bus.bbox_valid && bus.bbox_ready;
    assign bus.feat_valid = (cnt_q != '0);
    assign w_pop          = bus.feat_valid && bus.feat_ready;
    assign w_push         = s1_valid_q;

    assign w_head = mem_q[rd_ptr_q];
    assign {bus.cm_concate, bus.position_concate, bus.width, bus.height,
            bus.color1, bus.color2, bus.clip} = w_head;
    assign bus.obj_idx = pop_q;

    assign busy    = (state_q != S_IDLE);
    assign done_fe = (state_q == S_DONE);

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_fe) state_d = (num_obj == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_pop && ((pop_q + CNT_W'(1)) == num_q)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_fe) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- counters, stage-1, FIFO control ----------------
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            num_q      <= '0;
            acc_q      <= '0;
            pop_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else if (abort_fe) begin
            num_q      <= '0;
            acc_q      <= '0;
            pop_q      <= '0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_fe) begin
                num_q <= num_obj;
                acc_q <= '0;
                pop_q <= '0;
            end
            if (w_accept) begin
                acc_q     <= acc_q + CNT_W'(1);
                s1_data_q <= w_entry;
            end
            s1_valid_q <= w_accept;
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                pop_q    <= pop_q + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is reset so the head outputs read as zero out of reset.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (w_push && !abort_fe) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_oflow_feature_extraction_pipe.sv
`default_nettype none
`timescale 1ns/1ps
module tb_oflow_feature_extraction_pipe;
    localparam int COORD_W = 11, DIM_W = 8, COLOR_W = 24, FIFO_DEPTH = 4, CNT_W = 8;
    localparam int BBOX_W = 2*COORD_W + 2*DIM_W + 2*COLOR_W;
    localparam int EXP_W  = 6*COORD_W + 2*DIM_W + 2*COLOR_W + CNT_W + 1;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    logic start_fe = 1'b0;
    logic abort_fe = 1'b0;
    logic [CNT_W-1:0] num_obj = '0;
    logic busy, done_fe;

    oflow_feature_extraction_pipe_if #(.COORD_W(COORD_W), .DIM_W(DIM_W),
        .COLOR_W(COLOR_W), .CNT_W(CNT_W)) bus();

    oflow_feature_extraction_pipe #(.COORD_W(COORD_W), .DIM_W(DIM_W),
        .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_N(reset_N), .start_fe(start_fe), .num_obj(num_obj),
        .abort_fe(abort_fe), .bus(bus), .busy(busy), .done_fe(done_fe));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, fv_cnt = 0, acc = 0;
    logic [EXP_W-1:0] exp_q[$];

    // stimulus / expectation tables, indexed by object number in the batch
    logic [COORD_W-1:0] tx[8], ty[8], exbr[8], eybr[8], excm[8], eycm[8];
    logic [DIM_W-1:0]   tw[8], th[8];
    logic [COLOR_W-1:0] tc1[8], tc2[8];
    logic               eclip[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int x, input int y, input int w, input int h,
                           input int c1, input int c2, input int xbr, input int ybr,
                           input int xcm, input int ycm, input bit cl);
        tx[i] = COORD_W'(x); ty[i] = COORD_W'(y); tw[i] = DIM_W'(w); th[i] = DIM_W'(h);
        tc1[i] = COLOR_W'(c1); tc2[i] = COLOR_W'(c2);
        exbr[i] = COORD_W'(xbr); eybr[i] = COORD_W'(ybr);
        excm[i] = COORD_W'(xcm); eycm[i] = COORD_W'(ycm); eclip[i] = cl;
    endtask

    function automatic logic [BBOX_W-1:0] pack(input int i);
        return {tx[i], ty[i], tw[i], th[i], tc1[i], tc2[i]};
    endfunction

    task automatic push_exp(input int i);
        exp_q.push_back({excm[i], eycm[i], tx[i], ty[i], exbr[i], eybr[i],
                         tw[i], th[i], tc1[i], tc2[i], CNT_W'(i), eclip[i]});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_batch(input int n);
        start_fe = 1'b1; num_obj = CNT_W'(n);
        cyc(1);
        start_fe = 1'b0;
    endtask

    // Presents object 'acc' until accepted; stops at stop_at or after max_cyc cycles.
    task automatic drive(input int stop_at, input int max_cyc);
        int c = 0;
        bus.bbox_valid = 1'b1;
        while (acc < stop_at && c < max_cyc) begin
            bus.bbox = pack(acc);
            @(negedge clk);
            if (bus.bbox_ready) begin push_exp(acc); acc++; end
            cyc(1);
            c++;
        end
        bus.bbox_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin cyc(1); c++; end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compares the FIFO head whenever it is popped.
    logic [EXP_W-1:0] mon_act, mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (done_fe) done_cnt++;
            if (bus.feat_valid) fv_cnt++;
            if (bus.feat_valid && bus.feat_ready) begin
                mon_act = {bus.cm_concate, bus.position_concate, bus.width, bus.height,
                           bus.color1, bus.color2, bus.obj_idx, bus.clip};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL head_unexpected: got %h expected nothing queued", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL head: got %h expected %h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int d0, f0;
    initial begin
        bus.bbox = '0; bus.bbox_valid = 1'b0; bus.feat_ready = 1'b0;

        // ---- reset state ----
        cyc(3);
        reset_N = 1'b1;
        @(negedge clk);
        check("rst_bbox_ready", 64'(bus.bbox_ready), 64'd0);
        check("rst_feat_valid", 64'(bus.feat_valid), 64'd0);
        check("rst_done_fe", 64'(done_fe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cm", 64'(bus.cm_concate), 64'd0);
        check("rst_pos", 64'(bus.position_concate), 64'd0);
        check("rst_obj_idx", 64'(bus.obj_idx), 64'd0);
        check("rst_clip", 64'(bus.clip), 64'd0);
        check("rst_color1", 64'(bus.color1), 64'd0);
        cyc(1);

        // ---- single object, latency and done pulse ----
        set_vec(0, 100, 50, 20, 11, 24'hABCDEF, 24'h123456, 120, 61, 110, 55, 1'b0);
        bus.feat_ready = 1'b1; d0 = done_cnt; acc = 0;
        start_batch(1);
        bus.bbox = pack(0); bus.bbox_valid = 1'b1;
        @(negedge clk);
        check("t2_bbox_ready", 64'(bus.bbox_ready), 64'd1);
        push_exp(0); acc = 1;
        cyc(1); bus.bbox_valid = 1'b0;
        @(negedge clk);
        check("t2_fv_stage1", 64'(bus.feat_valid), 64'd0);
        cyc(1);
        @(negedge clk);
        check("t2_fv_latency", 64'(bus.feat_valid), 64'd1);
        cyc(1);
        @(negedge clk);
        check("t2_done_pulse", 64'(done_fe), 64'd1);
        check("t2_fv_after_pop", 64'(bus.feat_valid), 64'd0);
        cyc(1);
        @(negedge clk);
        check("t2_done_low", 64'(done_fe), 64'd0);
        check("t2_busy_low", 64'(busy), 64'd0);
        check("t2_done_count", 64'(done_cnt - d0), 64'd1);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        cyc(1);

        // ---- backpressure: 6 objects, FIFO of 4 ----
        for (int i = 0; i < 8; i++)
            set_vec(i, 10*i, 5*i, 4, 6, 24'h100000 + i, 24'h200000 + i,
                    10*i + 4, 5*i + 6, 10*i + 2, 5*i + 3, 1'b0);
        bus.feat_ready = 1'b0; d0 = done_cnt; acc = 0;
        start_batch(6);
        drive(6, 12);
        check("t3_accepted_stalled", 64'(acc), 64'd4);
        @(negedge clk);
        check("t3_bbox_ready_full", 64'(bus.bbox_ready), 64'd0);
        check("t3_fv_full", 64'(bus.feat_valid), 64'd1);
        check("t3_idx_held", 64'(bus.obj_idx), 64'd0);
        cyc(1);
        bus.feat_ready = 1'b1;
        drive(6, 20);
        check("t3_accepted_all", 64'(acc), 64'd6);
        drive(7, 4);
        check("t3_no_extra", 64'(acc), 64'd6);
        wait_drain(20);
        cyc(3);
        check("t3_done_count", 64'(done_cnt - d0), 64'd1);
        check("t3_busy_low", 64'(busy), 64'd0);

        // ---- coordinate overflow ----
`ifdef OFLOW_FE_CLAMP_EN
        set_vec(0, 2040, 0, 20, 8, 24'h0000FF, 24'hFF0000, 2047, 8, 2047, 4, 1'b1);
`else
        set_vec(0, 2040, 0, 20, 8, 24'h0000FF, 24'hFF0000, 12, 8, 2, 4, 1'b0);
`endif
        d0 = done_cnt; acc = 0;
        start_batch(1);
        drive(1, 10);
        wait_drain(20);
        cyc(3);
        check("t4_done_count", 64'(done_cnt - d0), 64'd1);

        // ---- empty batch ----
        d0 = done_cnt; f0 = fv_cnt;
        start_batch(0);
        @(negedge clk);
        check("t5_done_pulse", 64'(done_fe), 64'd1);
        check("t5_busy", 64'(busy), 64'd1);
        cyc(1);
        @(negedge clk);
        check("t5_done_low", 64'(done_fe), 64'd0);
        check("t5_busy_low", 64'(busy), 64'd0);
        cyc(3);
        check("t5_no_feat_valid", 64'(fv_cnt - f0), 64'd0);
        check("t5_done_count", 64'(done_cnt - d0), 64'd1);

        // ---- abort with simultaneous start ----
        for (int i = 0; i < 8; i++)
            set_vec(i, 10*i, 5*i, 4, 6, 24'h300000 + i, 24'h400000 + i,
                    10*i + 4, 5*i + 6, 10*i + 2, 5*i + 3, 1'b0);
        bus.feat_ready = 1'b0; d0 = done_cnt; acc = 0;
        start_batch(5);
        drive(3, 10);
        check("t6_accepted", 64'(acc), 64'd3);
        start_fe = 1'b1; num_obj = 8'd2;
        @(negedge clk);
        check("t6_busy_run", 64'(busy), 64'd1);
        check("t6_start_ignored", 64'(bus.bbox_ready), 64'd1);
        cyc(1);
        abort_fe = 1'b1;
        cyc(1);
        abort_fe = 1'b0; start_fe = 1'b0;
        @(negedge clk);
        check("t6_fv_flushed", 64'(bus.feat_valid), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_bbox_ready", 64'(bus.bbox_ready), 64'd0);
        exp_q.delete();
        cyc(3);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        bus.feat_ready = 1'b1; d0 = done_cnt; acc = 0;
        start_batch(1);
        drive(1, 10);
        wait_drain(20);
        cyc(3);
        check("t6_new_batch_done", 64'(done_cnt - d0), 64'd1);

        // ---- reset mid-batch with 2 entries queued ----
        bus.feat_ready = 1'b0; d0 = done_cnt; acc = 0;
        start_batch(4);
        drive(2, 10);
        cyc(2);
        @(negedge clk);
        check("t1_queued", 64'(bus.feat_valid), 64'd1);
        cyc(1);
        reset_N = 1'b0;
        #1;
        check("t1_rst_fv", 64'(bus.feat_valid), 64'd0);
        check("t1_rst_ready", 64'(bus.bbox_ready), 64'd0);
        check("t1_rst_busy", 64'(busy), 64'd0);
        check("t1_rst_done", 64'(done_fe), 64'd0);
        check("t1_rst_pos", 64'(bus.position_concate), 64'd0);
        check("t1_rst_cm", 64'(bus.cm_concate), 64'd0);
        exp_q.delete();
        cyc(2);
        reset_N = 1'b1;
        cyc(2);
        @(negedge clk);
        check("t1_fifo_empty", 64'(bus.feat_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_no_done", 64'(done_cnt - d0), 64'd0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
